trap_controller: RTL and testbench

Sequences trap entry and return for the core. Latches interrupt requests and arbitrates them against synchronous exceptions. Drives the one-cycle `csrWriteEnable` strobe that makes the CSR unit capture the faulting or interrupted PC into MEPC, then redirects fetch to the trap vector. Sits between the core's retire/exception signals, the MMIO bus interconnect, and the CSR unit, and owns all trap state-machine sequencing.

---
 rtl/trap_controller_if.sv | 28 ++
 rtl/trap_controller.sv | 164 ++++++++++++++++
 tb/tb_trap_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_controller_if.sv
// trap_bus_if
//   MMIO bus connection between the interconnect and trap_controller.
//   The interconnect (master) issues register writes and selects which
//   register drives busReadData. The trap controller (slave) returns the
//   read data combinationally.
//
//   busWriteEnable  master->slave  write strobe
//   busWriteSelect  master->slave  0 = irqEnable mask, 1 = pending W1C
//   busWriteData    master->slave  write data (low NUM_IRQ bits used)
//   busReadSelect   master->slave  0 mask, 1 pending, 2 trapCause, 3 status
//   busReadData     slave->master  read mux output
interface trap_bus_if;
    logic        busWriteEnable;
    logic        busWriteSelect;
    logic [31:0] busWriteData;
    logic [1:0]  busReadSelect;
    logic [31:0] busReadData;

    modport master (
        output busWriteEnable, busWriteSelect, busWriteData, busReadSelect,
        input  busReadData
    );

    modport slave (
        input  busWriteEnable, busWriteSelect, busWriteData, busReadSelect,
        output busReadData
    );
endinterface

// File: rtl/trap_controller.sv
// trap_controller
//   Sequences trap entry and return. Latches interrupt edges into a pending
//   register, arbitrates them against synchronous exceptions, strobes the
//   CSR unit to capture MEPC, redirects fetch to the trap vector and handles
//   MRET. An exception taken while already in the handler halts the core.
//
//   clock, resetActiveHigh   clock and asynchronous active-high reset
//   irqLines                 interrupt requests (rising edge sets pending)
//   exceptionValid/Code      synchronous exception and its cause
//   instructionRetire        instruction boundary; interrupts taken only here
//   mretValid                core executed MRET
//   bus                      MMIO register access (trap_bus_if.slave)
//   csrWriteEnable           one-cycle strobe: CSR unit captures PC
//   trapTaken, trapVector    PC mux selects the handler entry address
//   mretTaken                PC mux selects MEPC
//   coreStall                freeze fetch and retire
//   trapCause                bit31 = interrupt, low bits = code / IRQ index
//   inHandler, fatalError    handler active / sticky double-fault flag
module trap_controller #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic               clock,
    input  logic               resetActiveHigh,
    input  logic [NUM_IRQ-1:0] irqLines,
    input  logic               exceptionValid,
    input  logic [3:0]         exceptionCode,
    input  logic               instructionRetire,
    input  logic               mretValid,
    trap_bus_if.slave          bus,
    output logic               csrWriteEnable,
    output logic               trapTaken,
    output logic [31:0]        trapVector,
    output logic               mretTaken,
    output logic               coreStall,
    output logic [31:0]        trapCause,
    output logic               inHandler,
    output logic               fatalError
);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPTURE, S_REDIRECT, S_HANDLER, S_RETURN, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [31:0]        trap_cause_q, trap_cause_d;
    logic               fatal_q, fatal_d;
    logic               in_handler_q, in_handler_d;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] take_onehot;
    logic [NUM_IRQ-1:0] pending_clr;
    logic [3:0]         take_idx;
    logic               take_found;

    always_ff @(posedge clock or posedge resetActiveHigh) begin
        if (resetActiveHigh) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            trap_cause_q <= '0;
            fatal_q      <= 1'b0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_prev_d;
            trap_cause_q <= trap_cause_d;
            fatal_q      <= fatal_d;
            in_handler_q <= in_handler_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        trap_cause_d = trap_cause_q;
        fatal_d      = fatal_q;
        irq_prev_d   = irqLines;
        pending_clr  = '0;
        take_onehot  = '0;
        take_idx     = 4'd0;
        take_found   = 1'b0;

        irq_rise = irqLines & ~irq_prev_q;
        eligible = pending_q & mask_q;

        // Lowest-numbered eligible interrupt wins.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && !take_found) begin
                take_found     = 1'b1;
                take_idx       = 4'(i);
                take_onehot[i] = 1'b1;
            end
        end

        if (bus.busWriteEnable) begin
            if (bus.busWriteSelect)
                pending_clr = bus.busWriteData[NUM_IRQ-1:0];
            else
                mask_d = bus.busWriteData[NUM_IRQ-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (exceptionValid) begin
                    state_d      = S_CAPTURE;
                    trap_cause_d = {28'b0, exceptionCode};
                end else if (instructionRetire && take_found) begin
                    state_d      = S_CAPTURE;
                    trap_cause_d = {1'b1, 27'b0, take_idx};
                    pending_clr  = pending_clr | take_onehot;
                end
            end
            S_CAPTURE:  state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_HANDLER;
            S_HANDLER: begin
                // A second exception inside the handler is unrecoverable.
                if (exceptionValid) begin
                    state_d = S_HALT;
                    fatal_d = 1'b1;
                end else if (mretValid) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: state_d = S_IDLE;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // A new edge overrides a clear landing on the same bit.
        pending_d    = (pending_q & ~pending_clr) | irq_rise;
        in_handler_d = (state_d == S_HANDLER) || (state_d == S_RETURN) ||
                       (state_d == S_HALT);
    end

    // Strobes decode straight from the state register, so they fall the
    // instant reset asserts.
    assign csrWriteEnable = (state_q == S_CAPTURE);
    assign trapTaken      = (state_q == S_REDIRECT);
    assign mretTaken      = (state_q == S_RETURN);
    assign coreStall      = (state_q == S_CAPTURE) || (state_q == S_REDIRECT) ||
                            (state_q == S_RETURN)  || (state_q == S_HALT);
    assign trapVector     = TRAP_VECTOR;
    assign trapCause      = trap_cause_q;
    assign inHandler      = in_handler_q;
    assign fatalError     = fatal_q;

    always_comb begin
        case (bus.busReadSelect)
            2'd0:    bus.busReadData = 32'(mask_q);
            2'd1:    bus.busReadData = 32'(pending_q);
            2'd2:    bus.busReadData = trap_cause_q;
            default: bus.busReadData = {30'b0, fatal_q, in_handler_q};
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;
    logic        clock = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        exc;
    logic [3:0]  code;
    logic        retire;
    logic        mret;
    logic        csr_we, trap_taken, mret_taken, stall, in_handler, fatal;
    logic [31:0] trap_vector, trap_cause;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_q[$];

    trap_bus_if bus();

    trap_controller #(.NUM_IRQ(4), .TRAP_VECTOR(32'h0000_0100)) dut (
        .clock            (clock),
        .resetActiveHigh  (rst),
        .irqLines         (irq),
        .exceptionValid   (exc),
        .exceptionCode    (code),
        .instructionRetire(retire),
        .mretValid        (mret),
        .bus              (bus.slave),
        .csrWriteEnable   (csr_we),
        .trapTaken        (trap_taken),
        .trapVector       (trap_vector),
        .mretTaken        (mret_taken),
        .coreStall        (stall),
        .trapCause        (trap_cause),
        .inHandler        (in_handler),
        .fatalError       (fatal)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: every CSR capture strobe must match the next queued cause.
    always @(negedge clock) begin
        if (!rst && csr_we) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_trap got cause=%h required=no trap", trap_cause);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (trap_cause !== e) begin
                    failed++;
                    $display("FAIL trap_cause got=%h required=%h", trap_cause, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            failed++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic rd(input string name, input logic [1:0] sel, input logic [31:0] req);
        bus.busReadSelect = sel;
        #1;
        chk(name, bus.busReadData, req);
    endtask

    task automatic bus_wr(input logic sel, input logic [31:0] data);
        bus.busWriteEnable = 1'b1;
        bus.busWriteSelect = sel;
        bus.busWriteData   = data;
        step();
        bus.busWriteEnable = 1'b0;
    endtask

    // Walk CAPTURE -> REDIRECT -> HANDLER from the CAPTURE cycle.
    task automatic entry_tail();
        chk("capture_stall", {31'b0, stall}, 32'd1);
        step();
        chk("redirect_trapTaken", {31'b0, trap_taken}, 32'd1);
        chk("redirect_csr_low", {31'b0, csr_we}, 32'd0);
        step();
        chk("handler_inHandler", {31'b0, in_handler}, 32'd1);
        chk("handler_no_stall", {31'b0, stall}, 32'd0);
        chk("handler_trapTaken_low", {31'b0, trap_taken}, 32'd0);
    endtask

    task automatic do_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("return_mretTaken", {31'b0, mret_taken}, 32'd1);
        chk("return_stall", {31'b0, stall}, 32'd1);
        step();
        chk("idle_mretTaken_low", {31'b0, mret_taken}, 32'd0);
        chk("idle_inHandler_low", {31'b0, in_handler}, 32'd0);
        chk("idle_stall_low", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; irq = '0; exc = 1'b0; code = '0; retire = 1'b0; mret = 1'b0;
        bus.busWriteEnable = 1'b0; bus.busWriteSelect = 1'b0;
        bus.busWriteData = '0; bus.busReadSelect = 2'd0;
        step(); step();
        chk("rst_csr", {31'b0, csr_we}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_vector", trap_vector, 32'h0000_0100);
        chk("rst_cause", trap_cause, 32'd0);
        rd("rst_mask", 2'd0, 32'd0);
        rd("rst_pending", 2'd1, 32'd0);
        rd("rst_status", 2'd3, 32'd0);
        rst = 1'b0;
        step();

        // IRQ0 with retire held high
        bus_wr(1'b0, 32'h1);
        retire = 1'b1;
        exp_q.push_back(32'h8000_0000);
        irq[0] = 1'b1;
        step();
        chk("irq0_no_trap_yet", {31'b0, csr_we}, 32'd0);
        rd("irq0_pending_set", 2'd1, 32'h1);
        step();
        chk("irq0_csr", {31'b0, csr_we}, 32'd1);
        rd("irq0_pending_clr", 2'd1, 32'h0);
        retire = 1'b0;
        irq[0] = 1'b0;
        entry_tail();
        rd("irq0_cause_rd", 2'd2, 32'h8000_0000);
        do_mret();

        // exception beats an eligible IRQ2
        bus_wr(1'b0, 32'hF);
        irq[2] = 1'b1;
        step();
        rd("irq2_pending", 2'd1, 32'h4);
        exp_q.push_back(32'h0000_000B);
        exc = 1'b1; code = 4'hB; retire = 1'b1;
        step();
        exc = 1'b0; retire = 1'b0;
        chk("exc_csr", {31'b0, csr_we}, 32'd1);
        rd("exc_pending_kept", 2'd1, 32'h4);
        entry_tail();
        do_mret();
        exp_q.push_back(32'h8000_0002);
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("irq2_csr", {31'b0, csr_we}, 32'd1);
        entry_tail();
        rd("irq2_pending_clr", 2'd1, 32'h0);
        do_mret();
        irq = '0;

        // IRQ1 and IRQ3 both pending: IRQ1 first
        irq[1] = 1'b1; irq[3] = 1'b1;
        step();
        rd("irq13_pending", 2'd1, 32'hA);
        exp_q.push_back(32'h8000_0001);
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("irq1_csr", {31'b0, csr_we}, 32'd1);
        entry_tail();
        rd("irq3_left", 2'd1, 32'h8);
        do_mret();
        exp_q.push_back(32'h8000_0003);
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("irq3_csr", {31'b0, csr_we}, 32'd1);
        entry_tail();
        do_mret();
        irq = '0;

        // edge while in handler accumulates, W1C removes it
        exp_q.push_back(32'h0000_0003);
        exc = 1'b1; code = 4'h3;
        step();
        exc = 1'b0;
        entry_tail();
        irq[1] = 1'b1;
        step();
        rd("hnd_pending", 2'd1, 32'h2);
        chk("hnd_no_trap", {31'b0, csr_we}, 32'd0);
        chk("hnd_still_in", {31'b0, in_handler}, 32'd1);
        bus_wr(1'b1, 32'h2);
        rd("hnd_w1c", 2'd1, 32'h0);
        do_mret();
        retire = 1'b1;
        step();
        chk("no_trap_after_w1c_a", {31'b0, csr_we}, 32'd0);
        step();
        chk("no_trap_after_w1c_b", {31'b0, csr_we}, 32'd0);
        retire = 1'b0;

        // set wins over W1C on the same bit
        irq[0] = 1'b1;
        bus_wr(1'b1, 32'h1);
        rd("set_beats_clr", 2'd1, 32'h1);
        bus_wr(1'b1, 32'h1);
        rd("w1c_bit0", 2'd1, 32'h0);
        irq = '0;

        // masked IRQ not taken until the mask opens
        bus_wr(1'b0, 32'h0);
        retire = 1'b1;
        irq[2] = 1'b1;
        step(); step();
        chk("masked_no_trap", {31'b0, csr_we}, 32'd0);
        rd("masked_pending", 2'd1, 32'h4);
        exp_q.push_back(32'h8000_0002);
        bus_wr(1'b0, 32'h4);
        chk("mask_next_cycle", {31'b0, csr_we}, 32'd0);
        step();
        retire = 1'b0;
        chk("unmasked_csr", {31'b0, csr_we}, 32'd1);
        entry_tail();
        do_mret();
        irq = '0;

        // double fault
        exp_q.push_back(32'h0000_0005);
        exc = 1'b1; code = 4'h5;
        step();
        exc = 1'b0;
        entry_tail();
        exc = 1'b1; code = 4'h7;
        step();
        exc = 1'b0;
        chk("halt_fatal", {31'b0, fatal}, 32'd1);
        chk("halt_stall", {31'b0, stall}, 32'd1);
        rd("halt_status", 2'd3, 32'h3);
        mret = 1'b1;
        step();
        mret = 1'b0;
        chk("halt_mret_ignored", {31'b0, mret_taken}, 32'd0);
        step(); step();
        chk("halt_stall_sticky", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("halt_rst_stall", {31'b0, stall}, 32'd0);
        chk("halt_rst_fatal", {31'b0, fatal}, 32'd0);
        rd("halt_rst_status", 2'd3, 32'h0);
        step();
        rst = 1'b0;
        step();

        // reset during REDIRECT
        exp_q.push_back(32'h0000_0002);
        exc = 1'b1; code = 4'h2;
        step();
        exc = 1'b0;
        step();
        chk("redir_trapTaken", {31'b0, trap_taken}, 32'd1);
        rst = 1'b1;
        #1;
        chk("redir_rst_trapTaken", {31'b0, trap_taken}, 32'd0);
        chk("redir_rst_stall", {31'b0, stall}, 32'd0);
        chk("redir_rst_cause", trap_cause, 32'd0);
        rd("redir_rst_status", 2'd3, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle_csr", {31'b0, csr_we}, 32'd0);
        chk("post_rst_idle_stall", {31'b0, stall}, 32'd0);
        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
